// File: rtl/decode_queue.sv
// decode_queue
//   Decode-and-buffer stage in front of execute. Raw instruction words are
//   classified by opcode on the way in. Each word is stored in a small FIFO
//   together with its operation type. Entries are presented to execute over
//   a valid/ready handshake, so fetch stalls and execute stalls stay decoupled.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of the saturating unknown-opcode counter
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous queue clear; highest priority
//   in_valid     in_instr is valid
//   in_instr     raw 32-bit instruction word
//   in_ready     queue can accept a word this cycle (registered state only)
//   out_valid    head entry is valid
//   out_ready    execute consumes the head this cycle
//   out_type     head operation type (feeds operation.operation_type)
//   out_instr    head raw instruction word
//   count        occupancy
//   unknown_cnt  saturating count of accepted unknown-opcode words
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [31:0]                in_instr,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [1:0]                 out_type,
   output logic [31:0]                out_instr,
   output logic [$clog2(DEPTH):0]     count,
   output logic [CNT_W-1:0]           unknown_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   localparam logic [1:0] OPERATION_ALU     = 2'd0;
   localparam logic [1:0] OPERATION_MEM     = 2'd1;
   localparam logic [1:0] OPERATION_BRANCH  = 2'd2;
   localparam logic [1:0] OPERATION_UNKNOWN = 2'd3;

   function automatic logic [1:0] classify(input logic [6:0] opcode);
      logic [1:0] t;
      case (opcode)
         7'b0110011, 7'b0010011:             t = OPERATION_ALU;
         7'b0000011, 7'b0100011:             t = OPERATION_MEM;
         7'b1100011, 7'b1101111, 7'b1100111: t = OPERATION_BRANCH;
         default:                            t = OPERATION_UNKNOWN;
      endcase
      return t;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [31:0]      instr_mem [DEPTH];
   logic [1:0]       type_mem  [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [1:0]       in_type;
   logic             push;
   logic             pop;

   assign in_type   = classify(in_instr[6:0]);
   assign in_ready  = (count < FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   assign out_type  = type_mem[rd_ptr];
   assign out_instr = instr_mem[rd_ptr];

   // Storage: data only, never reset.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= in_instr;
         type_mem[wr_ptr]  <= in_type;
      end
   end

   // Control: pointers, occupancy and unknown-opcode counter.
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         unknown_cnt <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         // push is already masked by flush, so a flushed word is not counted
         if (push && (in_type == OPERATION_UNKNOWN))
            unknown_cnt <= sat_inc(unknown_cnt);
      end
   end

endmodule

// File: doc/decode_queue.md
# decode_queue

Decode-and-buffer stage that sits directly upstream of the execute stage. It accepts raw 32-bit instruction words over a valid/ready handshake and classifies each word by opcode into the `operation_type` encoding that execute dispatches on. Decoded entries are held in a small FIFO and presented to execute over a second valid/ready handshake, which decouples fetch stalls from execute stalls.

## Interface

- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `CNT_W`, default 16: width of the unknown-opcode counter.

Ports:

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `flush` in 1: synchronous queue clear.
- `in_valid` in 1: `in_instr` is valid.
- `in_instr` in 32: raw instruction word.
- `in_ready` out 1: the queue can accept a word this cycle.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: execute consumes the head this cycle.
- `out_type` out 2: head `operation_type`, wired to `operation.operation_type`.
- `out_instr` out 32: head raw instruction word.
- `count` out $clog2(DEPTH)+1: occupancy.
- `unknown_cnt` out CNT_W: saturating count of accepted unknown-opcode words.

## Operation

- Fixed type encoding: `OPERATION_ALU` = 2'd0, `OPERATION_MEM` = 2'd1, `OPERATION_BRANCH` = 2'd2, unknown = 2'd3.
- Classification uses `in_instr[6:0]`:
  - 7'b0110011 or 7'b0010011 → ALU.
  - 7'b0000011 or 7'b0100011 → MEM.
  - 7'b1100011, 7'b1101111 or 7'b1100111 → BRANCH.
  - All other values → 2'd3.
- Classification is combinational on the input side. The type is stored alongside the word at push time; the output side performs no re-decode.
- Push condition: `in_valid && in_ready && !flush`. The word is written at the tail, and the tail pointer advances modulo DEPTH.
- Pop condition: `out_valid && out_ready && !flush`. The head pointer advances modulo DEPTH.
- `in_ready` = (`count` < DEPTH). It depends only on registered state and has no combinational path from `out_ready`.
- `out_valid` = (`count` != 0). `out_type` and `out_instr` are read directly from storage at the head pointer.
- Simultaneous push and pop (not full, not empty): `count` is unchanged and both pointers advance.
- Full: `in_ready` = 0, including when a pop occurs the same cycle. Space is visible one cycle after the pop.
- Empty: `out_valid` = 0. `out_ready` is ignored, and `out_type`/`out_instr` are don't-care.
- Flush: highest priority.
  - Next edge: `count` = 0 and both pointers = 0.
  - A push or pop in the same cycle is discarded.
  - `unknown_cnt` is not affected.
- `unknown_cnt`:
  - Increments by 1 on each push of a 2'd3 word.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- Reset (asserted at any time, including mid-stream): immediately `count` = 0, pointers = 0, `unknown_cnt` = 0, `out_valid` = 0, `in_ready` = 1. Storage contents are not reset.

## Timing

- Latency: a word pushed at edge N into an empty queue gives `out_valid` = 1 with that entry during cycle N+1. It can be popped at edge N+1.
- Throughput: one push and one pop per cycle in steady state.
- Handshake rules on both sides:
  - A source holding valid must keep the data stable until the handshake completes.
  - The block never drops `out_valid` without a pop or a flush.
- Reset deassertion is synchronised externally. The first push is accepted on the first edge with `rst_n` high.

## Test plan

- Reset/idle: hold `rst_n` = 0, then release. Required: `count` = 0, `in_ready` = 1, `out_valid` = 0, `unknown_cnt` = 0.
- Classification: push 0x00B50533, 0x0005A503, 0x00B50463, 0xFFFFFFFF with `out_ready` = 1. Required: `out_type` sequence 0, 1, 2, 3, each one cycle after its push, and `unknown_cnt` = 1.
- Fill/backpressure: hold `out_ready` = 0 and push 5 words with DEPTH = 4.
  - Required: `in_ready` falls after the 4th push, `count` = 4, and the 5th word is not accepted.
  - Then pulse `out_ready` for one cycle: `in_ready` = 1 the next cycle.
  - Drain: the words come out in order.
- Concurrent push/pop at `count` = 2 for 10 cycles. Required: `count` stays 2 and output order matches input order, including across pointer wrap-around.
- Flush: with `count` = 3, assert `flush` together with `in_valid` and `out_ready`. Required:
  - Next cycle `count` = 0 and `out_valid` = 0.
  - The same-cycle word is absent.
  - `unknown_cnt` is unchanged.
- Reset mid-operation and saturation:
  - Drop `rst_n` with `count` = 2. Required: immediate `out_valid` = 0 and `count` = 0.
  - With CNT_W = 2, push 5 unknown words. Required: `unknown_cnt` saturates at 3.
